// File: rtl/pca9685_sequencer_if.sv
// Single-register write handshake between the PCA9685 sequencer and the I2C controller.
// The sequencer owns the transaction fields and execute; the controller returns busy.
interface pca9685_sequencer_if;
   logic [6:0] address;
   logic       rw;
   logic [7:0] register_id;
   logic [7:0] register_value;
   logic       execute;
   logic       busy;

   modport master (
      output address,
      output rw,
      output register_id,
      output register_value,
      output execute,
      input  busy
   );

   modport slave (
      input  address,
      input  rw,
      input  register_id,
      input  register_value,
      input  execute,
      output busy
   );
endinterface

// File: rtl/pca9685_sequencer.sv
// Turns init / channel requests into ordered single-register PCA9685 writes for i2c_controller,
// holding each transaction's fields stable and flagging a controller that never goes busy.
module pca9685_sequencer #(
   parameter logic [6:0]  DEVICE_ADDR    = 7'h40,
   parameter logic [7:0]  PRESCALE_VALUE = 8'd121,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       init_i,
   input  logic                       write_i,
   input  logic [3:0]                 ch_i,
   input  logic [12:0]                on_i,
   input  logic [12:0]                off_i,
   output logic                       ready_o,
   output logic                       done_o,
   output logic                       error_o,
   pca9685_sequencer_if.master        ctrl
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StIssue, StWaitDone} state_e;

   state_e          state_q;
   logic [1:0]      idx_q;
   logic            init_q;
   logic [3:0]      ch_q;
   logic [12:0]     on_q;
   logic [12:0]     off_q;
   logic [CntW-1:0] cnt_q;
   logic            busy_s1_q;
   logic            busy_s2_q;
   logic            execute_q;
   logic            done_q;
   logic            error_q;
   logic [7:0]      reg_id_q;
   logic [7:0]      reg_val_q;
   logic [1:0]      last_idx;
   logic [1:0]      idx_next;

   // Returns {register_id, register_value} for one step of either sequence.
   function automatic logic [15:0] step_fields(input logic        is_init,
                                               input logic [1:0]  idx,
                                               input logic [3:0]  ch,
                                               input logic [12:0] on,
                                               input logic [12:0] off);
      logic [7:0] base;
      logic [15:0] f;
      base = 8'h06 + {2'b00, ch, 2'b00};
      f    = 16'h0000;
      if (is_init) begin
         unique case (idx)
            2'd0:    f = {8'h00, 8'h10};
            2'd1:    f = {8'hFE, PRESCALE_VALUE};
            2'd2:    f = {8'h00, 8'h20};
            default: f = 16'h0000;
         endcase
      end else begin
         unique case (idx)
            2'd0: f = {base,         on[7:0]};
            2'd1: f = {base + 8'd1, {3'b000, on[12:8]}};
            2'd2: f = {base + 8'd2,  off[7:0]};
            2'd3: f = {base + 8'd3, {3'b000, off[12:8]}};
         endcase
      end
      return f;
   endfunction

   always_comb begin
      ready_o  = (state_q == StIdle) && !busy_s2_q;
      last_idx = init_q ? 2'd2 : 2'd3;
      idx_next = idx_q + 2'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         idx_q     <= 2'd0;
         init_q    <= 1'b0;
         ch_q      <= 4'd0;
         on_q      <= 13'd0;
         off_q     <= 13'd0;
         cnt_q     <= '0;
         busy_s1_q <= 1'b1;
         busy_s2_q <= 1'b1;
         execute_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         reg_id_q  <= 8'd0;
         reg_val_q <= 8'd0;
      end else begin
         busy_s1_q <= ctrl.busy;
         busy_s2_q <= busy_s1_q;
         done_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if ((init_i || write_i) && ready_o) begin
                  init_q  <= init_i;
                  ch_q    <= ch_i;
                  on_q    <= on_i;
                  off_q   <= off_i;
                  error_q <= 1'b0;
                  idx_q   <= 2'd0;
                  // Fields are loaded on entry to LOAD so they lead execute by a cycle.
                  {reg_id_q, reg_val_q} <= step_fields(init_i, 2'd0, ch_i, on_i, off_i);
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               cnt_q     <= '0;
               execute_q <= 1'b1;
               state_q   <= StIssue;
            end
            StIssue: begin
               if (busy_s2_q) begin
                  execute_q <= 1'b0;
                  state_q   <= StWaitDone;
               end else if (cnt_q == CntLast) begin
                  execute_q <= 1'b0;
                  error_q   <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWaitDone: begin
               if (!busy_s2_q) begin
                  if (idx_q == last_idx) begin
                     done_q  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     idx_q <= idx_next;
                     {reg_id_q, reg_val_q} <= step_fields(init_q, idx_next, ch_q, on_q, off_q);
                     state_q <= StLoad;
                  end
               end
            end
         endcase
      end
   end

   assign done_o               = done_q;
   assign error_o              = error_q;
   assign ctrl.address         = DEVICE_ADDR;
   assign ctrl.rw              = 1'b0;
   assign ctrl.register_id     = reg_id_q;
   assign ctrl.register_value  = reg_val_q;
   assign ctrl.execute         = execute_q;
endmodule
